// File: rtl/rx_frame_buffer.sv
// Synchronises the UART receiver's level outputs, validates each completed frame and
// queues payload plus error flags in a show-ahead FIFO. Optional macro: RX_PARITY_CHECK_EN.
module rx_frame_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       rx_frame,
  input  logic              rx_valid,
  input  logic              rx_ferror,
  output logic [7:0]        out_data,
  output logic [1:0]        out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overrun,
  input  logic              clear_overrun
);

  typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;

  state_t state, state_next;

  logic valid_s1, valid_s2, valid_prev;
  logic ferr_s1, ferr_s2;
  logic new_frame;

  logic [7:0] data_q;
  logic       start_q, stop_q, ferr_q;
  logic       framing_flag, parity_flag;
  logic       do_push, busy_hit;

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              full, empty, pop, push_ok, drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1   <= 1'b0;
      valid_s2   <= 1'b0;
      valid_prev <= 1'b0;
      ferr_s1    <= 1'b0;
      ferr_s2    <= 1'b0;
    end else begin
      valid_s1   <= rx_valid;
      valid_s2   <= valid_s1;
      valid_prev <= valid_s2;
      ferr_s1    <= rx_ferror;
      ferr_s2    <= ferr_s1;
    end
  end

  // Only a rising edge of the synchronised level marks a new frame.
  assign new_frame = valid_s2 & ~valid_prev;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_push    = 1'b0;
    busy_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (new_frame) state_next = CHECK;
      end
      CHECK: begin
        busy_hit   = new_frame;
        state_next = PUSH;
      end
      PUSH: begin
        busy_hit   = new_frame;
        do_push    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RX_PARITY_CHECK_EN
  logic pbit_q;

  always_ff @(posedge clk) begin
    if (reset)               pbit_q <= 1'b0;
    else if (state == CHECK) pbit_q <= rx_frame[9];
  end

  assign parity_flag = (^{pbit_q, data_q}) != 1'(PARITY_ODD);
`else
  logic unused_parity_bit;

  assign unused_parity_bit = rx_frame[9];
  assign parity_flag       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b1;
      ferr_q  <= 1'b0;
    end else if (state == CHECK) begin
      data_q  <= rx_frame[8:1];
      start_q <= rx_frame[0];
      stop_q  <= rx_frame[10];
      ferr_q  <= ferr_s2;
    end
  end

  assign framing_flag = start_q | ~stop_q | ferr_q;

  // Occupancy alone decides full/empty, so the pointers can be plain wrapping counters.
  assign empty   = (fifo_count == '0);
  assign full    = (fifo_count == (ADDR_W+1)'(DEPTH));
  assign pop     = ~empty & out_ready;
  assign push_ok = do_push & (~full | pop);
  assign drop    = do_push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= {parity_flag, framing_flag, data_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A new overrun event takes priority over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset)                  overrun <= 1'b0;
    else if (busy_hit || drop)  overrun <= 1'b1;
    else if (clear_overrun)     overrun <= 1'b0;
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign out_err   = out_valid ? mem[rd_ptr][9:8] : 2'b00;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: a behavioural model predicts FIFO contents,
// occupancy and the overrun flag; a monitor compares against the DUT every cycle.
module tb_rx_frame_buffer;

  localparam int DEPTH      = 8;
  localparam int ADDR_W     = 3;
  localparam int PARITY_ODD = 0;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [10:0]     rx_frame = '0;
  logic            rx_valid = 1'b0;
  logic            rx_ferror = 1'b0;
  logic [7:0]      out_data;
  logic [1:0]      out_err;
  logic            out_valid;
  logic            out_ready;
  logic [ADDR_W:0] fifo_count;
  logic            overrun;
  logic            clear_overrun = 1'b0;

  logic dir_ready  = 1'b0;
  logic rand_ready = 1'b0;
  logic rnd_ready  = 1'b0;
  int   ready_pct  = 50;
  logic mon_en     = 1'b0;

  int checks = 0;
  int errors = 0;

  rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .reset(reset), .rx_frame(rx_frame), .rx_valid(rx_valid),
    .rx_ferror(rx_ferror), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_ready : dir_ready;

  always @(negedge clk) rnd_ready = ($urandom_range(0, 99) < ready_pct);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mkFrame(input logic [7:0] d);
    logic p;
    p = (^d) ^ (PARITY_ODD != 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Flags straight from the frame rules: start must be 0, stop 1, parity count must match.
  function automatic logic [1:0] expectErr(input logic [10:0] f, input logic fe);
    logic fr, par;
    fr  = (f[0] != 1'b0) || (f[10] != 1'b1) || fe;
`ifdef RX_PARITY_CHECK_EN
    par = ($countones(f[9:1]) % 2) != PARITY_ODD;
`else
    par = 1'b0;
`endif
    return {par, fr};
  endfunction

  typedef struct { int due; logic [7:0] d; logic [1:0] e; } evt_t;
  typedef struct { logic [7:0] d; logic [1:0] e; } ent_t;

  evt_t nf_q[$];
  evt_t push_q[$];
  ent_t exp_q[$];
  int   cyc = 0;
  int   last_accept = -100;
  int   model_count = 0;
  logic model_overrun = 1'b0;
  logic prev_valid = 1'b0;

  // Reference model: a rising rx_valid is recognised two edges after it is first sampled;
  // the block is then busy for three edges and the entry lands two edges after acceptance.
  always @(posedge clk) begin
    logic pop, set_ov;
    evt_t ev;
    if (reset) begin
      nf_q.delete();
      push_q.delete();
      exp_q.delete();
      model_count   = 0;
      model_overrun = 1'b0;
      prev_valid    = 1'b0;
      last_accept   = -100;
    end else begin
      pop    = (model_count > 0) && out_ready;
      set_ov = 1'b0;
      if (rx_valid && !prev_valid)
        nf_q.push_back('{cyc + 2, rx_frame[8:1], expectErr(rx_frame, rx_ferror)});
      prev_valid = rx_valid;
      if (nf_q.size() > 0 && nf_q[0].due == cyc) begin
        ev = nf_q.pop_front();
        if (cyc - last_accept >= 3) begin
          last_accept = cyc;
          push_q.push_back('{cyc + 2, ev.d, ev.e});
        end else begin
          set_ov = 1'b1;
        end
      end
      if (push_q.size() > 0 && push_q[0].due == cyc) begin
        ev = push_q.pop_front();
        if (model_count == DEPTH && !pop) begin
          set_ov = 1'b1;
        end else begin
          exp_q.push_back('{ev.d, ev.e});
          model_count++;
        end
      end
      if (pop) model_count--;
      if (set_ov)             model_overrun = 1'b1;
      else if (clear_overrun) model_overrun = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    ent_t head;
    if (mon_en) begin
      #1;
      checkOutput("fifo_count", 32'(fifo_count), 32'(model_count));
      checkOutput("out_valid", 32'(out_valid), 32'(model_count != 0));
      checkOutput("overrun", 32'(overrun), 32'(model_overrun));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL head_entry: got data %0h with no expected entry at %0t", out_data, $time);
        end else begin
          head = exp_q[0];
          checkOutput("head_data", 32'(out_data), 32'(head.d));
          checkOutput("head_err", 32'(out_err), 32'(head.e));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [10:0] f, input logic fe, input int high, input int low);
    @(negedge clk);
    rx_frame  = f;
    rx_ferror = fe;
    rx_valid  = 1'b1;
    repeat (high) @(negedge clk);
    rx_valid = 1'b0;
    repeat (low - 1) @(negedge clk);
  endtask

  task automatic popOne();
    @(negedge clk);
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    dir_ready = 1'b1;
    for (int i = 0; i < 100 && out_valid; i++) @(negedge clk);
    dir_ready = 1'b0;
    #1 checkOutput(name, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] f;
    logic [7:0]  d;
    logic [1:0]  e74a;

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] clean frame and latency");
    @(negedge clk);
    rx_frame = 11'h54A; rx_ferror = 1'b0; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkOutput("latency_edge4_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("latency_edge5_valid", 32'(out_valid), 32'd1);
    checkOutput("clean_data", 32'(out_data), 32'hA5);
    checkOutput("clean_err", 32'(out_err), 32'd0);
    popOne();
    #1 checkOutput("clean_pop_count", 32'(fifo_count), 32'd0);

    $display("[TB] bad stop bit");
    applyStimulus(11'h14A, 1'b0, 1, 5);
    #1;
    checkOutput("badstop_data", 32'(out_data), 32'hA5);
    checkOutput("badstop_err", 32'(out_err), 32'b01);
    popOne();

    $display("[TB] parity bit set");
`ifdef RX_PARITY_CHECK_EN
    e74a = 2'b10;
`else
    e74a = 2'b00;
`endif
    applyStimulus(11'h74A, 1'b0, 1, 5);
    #1 checkOutput("parity_err", 32'(out_err), 32'(e74a));
    popOne();

    $display("[TB] overflow");
    for (int i = 0; i <= DEPTH; i++) applyStimulus(mkFrame(8'(i)), 1'b0, 1, 4);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("overflow_count", 32'(fifo_count), 32'(DEPTH));
    checkOutput("overflow_flag", 32'(overrun), 32'd1);
    drain("overflow_drain");
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    #1 checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] full with simultaneous push and pop");
    for (int i = 0; i < DEPTH; i++) applyStimulus(mkFrame(8'(8'h40 + i)), 1'b0, 1, 4);
    @(negedge clk);
    rx_frame = mkFrame(8'h4F); rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
    #1;
    checkOutput("fullpp_count", 32'(fifo_count), 32'(DEPTH));
    checkOutput("fullpp_overrun", 32'(overrun), 32'd0);
    drain("fullpp_drain");

    $display("[TB] frame arriving while busy");
    @(negedge clk);
    rx_frame = mkFrame(8'h3C); rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("busy_count", 32'(fifo_count), 32'd1);
    checkOutput("busy_overrun", 32'(overrun), 32'd1);

    $display("[TB] reset during push");
    applyStimulus(mkFrame(8'h11), 1'b0, 1, 4);
    applyStimulus(mkFrame(8'h22), 1'b1, 1, 4);
    repeat (2) @(negedge clk);
    #1 checkOutput("prereset_count", 32'(fifo_count), 32'd3);
    @(negedge clk);
    rx_frame = mkFrame(8'h33); rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_count", 32'(fifo_count), 32'd0);
    checkOutput("midreset_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_overrun", 32'(overrun), 32'd0);
    applyStimulus(mkFrame(8'h5A), 1'b0, 1, 5);
    #1 checkOutput("postreset_data", 32'(out_data), 32'h5A);
    popOne();

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      ready_pct = (n < 40) ? 15 : 60;
      d = 8'($urandom);
      f = mkFrame(d);
      if ($urandom_range(0, 9) == 0) f[0]  = 1'b1;
      if ($urandom_range(0, 9) == 0) f[10] = 1'b0;
      if ($urandom_range(0, 9) == 0) f[9]  = ~f[9];
      clear_overrun = ($urandom_range(0, 7) == 0);
      applyStimulus(f, ($urandom_range(0, 9) == 0), $urandom_range(1, 3), $urandom_range(3, 6));
    end
    clear_overrun = 1'b0;
    repeat (6) @(negedge clk);
    rand_ready = 1'b0;
    drain("random_drain");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
Downstream consumer of the UART reception stage. It detects each newly completed 11-bit received frame and checks the start, stop and parity bits. It then pushes the 8-bit payload plus error flags into a small show-ahead FIFO, which the host logic drains with a valid/ready handshake. It also supplies the clock-domain crossing for the receiver's level outputs.

Parameters:
DEPTH, 8, FIFO entries; must be a power of two, 2..64.
ADDR_W, 3, log2(DEPTH).
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
clk  input  1  system clock, all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_frame  input  11  received frame: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
rx_valid  input  1  frame-complete level from the receiver; asynchronous to clk.
rx_ferror  input  1  receiver framing-error level; asynchronous to clk.
out_data  output  8  payload at the FIFO head.
out_err  output  2  head flags: [0] framing error, [1] parity error.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts the head entry.
fifo_count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.
overrun  output  1  sticky flag: a frame was dropped.
clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_err=0, fifo_count=0, overrun=0. Reset also clears the synchronisers, the edge-detect register, the read/write pointers and the FSM (state IDLE).
- Reset asserted mid-frame or mid-push discards everything; no partial write occurs.
- Synchronisation: rx_valid and rx_ferror each pass through a 2-flop synchroniser.
  - new_frame = synced rx_valid high AND its previous registered value low (rising edge only).
  - The upstream stage must deassert rx_valid between frames.
- FSM states:
  - IDLE: on new_frame, go to CHECK.
  - CHECK: register rx_frame and the synced rx_ferror, then go to PUSH.
  - PUSH: compute the flags, then write to the FIFO or drop the frame, then return to IDLE.
- new_frame arriving while in CHECK or PUSH: frame ignored, overrun set to 1.
- Flags:
  - framing = (frame[0]!=0) OR (frame[10]!=1) OR synced rx_ferror.
  - parity = (XOR of frame[9:1]) != PARITY_ODD.
- Latency: if the FIFO is empty, out_valid rises after the 5th rising edge, counting the first edge that samples rx_valid high.
- FIFO behaviour:
  - Show-ahead: out_data and out_err present the head entry whenever out_valid=1.
  - Pop occurs when out_valid AND out_ready; the pointer advances on that edge.
  - out_ready while empty has no effect.
- Push while full with no pop: frame dropped, overrun set to 1, fifo_count stays DEPTH.
- Push and pop in the same cycle:
  - When full, both are performed and fifo_count stays DEPTH.
  - When empty, only the push is performed.
  - Otherwise fifo_count is unchanged.
- Pointers are ADDR_W bits and wrap modulo DEPTH. The full/empty decision uses fifo_count.
- Error-flagged frames are stored like any other frame; they are not discarded.
- overrun: if clear_overrun and a new overrun event occur in the same cycle, the set wins.

Optional Feature:
RX_PARITY_CHECK_EN.
- Defined: the parity flag is computed as above.
- Undefined: frame[9] is ignored and out_err[1] is tied to 0; the framing check and everything else are unchanged.

Test Plan:
- Clean frame: rx_frame=11'h54A (data 8'hA5, even parity 0), pulse rx_valid -> 5 edges later out_valid=1, out_data=8'hA5, out_err=2'b00; pop -> fifo_count=0.
- Bad stop bit: rx_frame=11'h14A -> out_data=8'hA5, out_err=2'b01.
- Bad parity: rx_frame=11'h74A with the macro defined -> out_err=2'b10; same frame with the macro undefined -> out_err=2'b00.
- Overflow: out_ready=0, deliver DEPTH+1=9 frames 8'h00..8'h08 -> fifo_count=8, overrun=1; draining yields 00..07 in order; clear_overrun -> overrun=0.
- Full with simultaneous push and pop: fill to 8, hold out_ready=1 while a 9th frame is pushed -> overrun stays 0, fifo_count stays 8, ordering preserved across pointer wrap.
- Reset mid-stream: assert reset during PUSH with 3 entries stored -> next cycle fifo_count=0, out_valid=0, overrun=0; the following frame is processed normally.
